// File: rtl/nibble_serial_adder_fa4.sv
// 4-bit ripple-carry full adder: the one shared arithmetic slice of the
// serial adder. It is purely combinational, and the caller registers the carry.
module fa_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // Ripple the carry through four single-bit full adders
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor. It uses one fa_4 slice and handles
// one nibble per clock, starting with the LSB nibble.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps valid and its data steady until that edge. The
// consumer may hold ready low for as long as it likes, and the outputs do not
// change while out_valid is high.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic [WIDTH-1:0] sum_reg_q, sum_reg_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       fa_s;
    logic             fa_co;
    logic [WIDTH+3:0] sum_shift;

    fa_4 u_fa (
        .a  (a_reg_q[3:0]),
        .b  (b_reg_q[3:0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // The new nibble enters at the top, and earlier nibbles move down by 4
    assign sum_shift = {fa_s, sum_reg_q};

    // Single-process control: accept operands, step one nibble, hold result
    always_comb begin
        state_d   = state_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        sum_reg_d = sum_reg_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Subtract as a + ~b + 1, so the datapath only ever adds
                    a_reg_d = a;
                    b_reg_d = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : c_in;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_reg_d = sum_shift[WIDTH+3:4];
                carry_d   = fa_co;
                a_reg_d   = a_reg_q >> 4;
                b_reg_d   = b_reg_q >> 4;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    c_out_d = fa_co;
                    ovf_d   = (a_msb_q == b_msb_q) && (fa_s[3] != a_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            sum_reg_q <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            sum_reg_q <= sum_reg_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            a_msb_q   <= a_msb_d;
            b_msb_q   <= b_msb_d;
            c_out_q   <= c_out_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_reg_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that time-shares a single FA_4 4-bit ripple adder, one nibble per clock, LSB nibble first. A registered carry links nibbles across cycles. Valid/ready handshakes on both the operand side and the result side let it sit between a register-file read port and a writeback stage, where area matters more than latency.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4
- NIB (localparam), WIDTH/4, nibble count per operation
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c_in  in  1  carry-in for add; ignored when sub=1
- sub  in  1  1: compute a − b (two's complement)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- sum  out  WIDTH  result
- c_out  out  1  carry-out of the top nibble; for sub, 1 = no borrow
- ovf  out  1  signed overflow
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch a_reg=a.
  - Latch b_reg = sub ? ~b : b.
  - Set carry = sub ? 1 : c_in.
  - Capture sign bits a_msb=a[WIDTH-1] and b_msb=b_reg MSB (post-inversion).
  - Set cnt=0 and go to RUN.
- RUN: FA_4 adds a_reg[3:0] + b_reg[3:0] + carry. Each cycle:
  - The nibble sum shifts into sum_reg from the top (sum_reg >> 4, new nibble at [WIDTH-1:WIDTH-4]).
  - carry takes the FA_4 c_out.
  - a_reg and b_reg shift right by 4.
  - cnt increments.
- RUN, last nibble (cnt==NIB-1): additionally register c_out=carry result and ovf=(a_msb==b_msb)&&(new sum MSB≠a_msb), then go to DONE.
- DONE: out_valid=1. sum, c_out and ovf stay stable until out_valid&&out_ready, then go to IDLE.
- in_ready is 0 in RUN and DONE; in_valid is ignored there.
- Result is mod 2^WIDTH; no saturation.
- cnt width is clog2(NIB), min 1 bit. Wrap is never reached because the transition fires at NIB-1.
- WIDTH=4: a single RUN cycle, then DONE.

## Timing
- Reset (async assert, sync release internally not required) values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, c_out=0, ovf=0, carry=0, cnt=0.
- Accept at edge E0. Nibble k is written at edge E(k+1). out_valid rises after edge E(NIB). Latency is NIB cycles from accept to out_valid.
- out_ready high in the first DONE cycle → IDLE after the next edge; in_ready is high one cycle later. Minimum issue interval is NIB+2 cycles.
- out_ready may be held low indefinitely; outputs must not change while out_valid=1.
- in_valid asserted during RUN/DONE: no accept, no state change. The requester must hold the request until in_ready.
- Reset asserted mid-RUN or in DONE: immediately return to reset values. The partial result is discarded and no out_valid pulse occurs.
- Outputs are all registered. in_ready and busy decode from state only. There is no combinational in→out path.

## Structure
- Single module plus one FA_4 instance (the 4-bit datapath). No other sub-modules.
- State encoding and NIB are local parameters. No shared package; a codebase-wide defines file is not needed for this block.
- The datapath regs are a_reg, b_reg, sum_reg, carry and cnt. Control is a single-process FSM.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, c_in=0, sub=0 → out_valid after 4 cycles; sum=0x5555, c_out=0, ovf=0.
- a=0xFFFF, b=0x0001, c_in=0 → sum=0x0000, c_out=1, ovf=0. Repeat with a=0x00FF, b=0x0001 to check carry propagation across nibbles: sum=0x0100.
- a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, c_out=0.
- sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, c_out=0. Also sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, ovf=1, c_out=1.
- Hold out_ready=0 for 5 cycles in DONE → sum/c_out/ovf stable, in_ready=0, second in_valid ignored. Then out_ready=1 → IDLE, the next operands are accepted, and the result is correct.
- Assert rst_n=0 at the 2nd RUN cycle → all outputs at reset values immediately. After release, a fresh 0x0001+0x0001 yields 0x0002 with no stale carry.
